serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing Diff = A − B one bit per clock, LSB first, using a half/full-subtractor cell and a registered borrow flip-flop. It is the arithmetic inverse of the existing half-adder datapath, with a start/busy/done handshake so a controller or testbench can launch operations and collect results. It sits beside the adder examples as the team's first multi-cycle arithmetic unit.

---
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    count;
    logic             br;

    logic             d;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    // Full-subtractor cell on the current LSBs
    assign d        = sa[0] ^ sb[0] ^ br;
    assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last_bit = (count == CW'(WIDTH - 1));
    assign shifted  = {d, sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            count <= '0;
            br    <= 1'b0;
            Diff  <= '0;
            B_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        sr    <= '0;
                        count <= '0;
                        br    <= 1'b0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= shifted[WIDTH-1:1];
                    br    <= br_next;
                    count <= count + 1'b1;
                    // Only the completion edge exposes a result
                    if (last_bit) begin
                        Diff  <= shifted;
                        B_out <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy8, done8, bout8;
    logic       busy4, done4, bout4;
    logic [7:0] diff8;
    logic [3:0] diff4;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] last8 = '0;
    logic       lastb8 = 1'b0;
    logic [3:0] last4 = '0;
    logic       lastb4 = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Diff(diff8), .B_out(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Diff(diff4), .B_out(bout4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: result from plain modular arithmetic, handshake from the edge schedule
    task automatic op(input bit w4, input int unsigned a, input int unsigned b);
        int          w;
        int unsigned mask;
        int unsigned ed;
        bit          eb;
        logic [31:0] prev_d;
        logic        prev_b;
        logic [31:0] o_diff;
        logic        o_busy, o_done, o_bout;
        w      = w4 ? 4 : 8;
        mask   = (32'd1 << w) - 1;
        ed     = (a - b) & mask;
        eb     = (a & mask) < (b & mask);
        prev_d = w4 ? 32'(last4) : 32'(last8);
        prev_b = w4 ? lastb4 : lastb8;
        if (w4) begin
            a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom);
        for (int n = 1; n <= w + 1; n++) begin
            @(posedge clk); #1;
            o_busy = w4 ? busy4 : busy8;
            o_done = w4 ? done4 : done8;
            o_diff = w4 ? 32'(diff4) : 32'(diff8);
            o_bout = w4 ? bout4 : bout8;
            check("busy", 32'(o_busy), 32'(n <= w));
            check("done", 32'(o_done), 32'(n == w));
            if (n < w) begin
                check("diff_hold", o_diff, prev_d);
                check("bout_hold", 32'(o_bout), 32'(prev_b));
            end else begin
                check("diff", o_diff, ed);
                check("bout", 32'(o_bout), 32'(eb));
            end
        end
        if (w4) begin
            last4 = ed[3:0]; lastb4 = eb;
        end else begin
            last8 = ed[7:0]; lastb8 = eb;
        end
    endtask

    initial begin
        int last_done;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_diff", 32'(diff8), 0);
        check("rst_bout", 32'(bout8), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(0, 5, 3);
        op(0, 3, 5);
        op(0, 8'h00, 8'h01);
        op(0, 8'hFF, 8'hFF);
        op(0, 8'h00, 8'h00);
        op(0, 8'h80, 8'h7F);
        for (int i = 0; i < 30; i++) op(0, $urandom_range(0, 255), $urandom_range(0, 255));

        // start held high: a new op only every WIDTH+2 cycles, operands scrambled mid-run
        a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
        last_done = -1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk); #1;
            if (done8) begin
                check("cont_diff", 32'(diff8), 5);
                check("cont_bout", 32'(bout8), 0);
                if (last_done >= 0) check("cont_period", cyc - last_done, 10);
                last_done = cyc;
            end else if (last_done >= 0) begin
                check("cont_hold", 32'(diff8), 5);
            end
            if (!busy8) begin
                a8 = 8'd9; b8 = 8'd4;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        for (int i = 0; i < 20 && busy8; i++) begin
            @(posedge clk); #1;
        end
        check("cont_drain", 32'(busy8), 0);
        check("cont_seen", 32'(last_done >= 0), 1);
        last8 = 8'd5; lastb8 = 1'b0;

        // Reset in the middle of a run
        op(0, 5, 3);
        a8 = 8'd10; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 0);
        check("abort_done", 32'(done8), 0);
        check("abort_diff", 32'(diff8), 0);
        check("abort_bout", 32'(bout8), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", 32'(done8), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_idle", 32'(done8 | busy8), 0);
        end
        last8 = '0; lastb8 = 1'b0;
        last4 = '0; lastb4 = 1'b0;
        op(0, 10, 7);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op(1, a, b);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
